seq_accum_processor: RTL and testbench
======================================

// Module: seq_accum_processor
// PURPOSE
//  Parametrised FSM+datapath processor that accumulates an arithmetic index series.
//  The series is i = 0, step, 2*step, ... while i <= limit; each term is i (SUM) or i*i (SQSUM).
//  Emits each running total on out_buf with an out_valid pulse, then pulses done.
//  Runs under an internal clock-enable tick, so the board build and the sim build use the same clk.
// PARAMETERS
//  WIDTH     8  datapath width of limit, step, accumulator and out_buf
//  TICK_DIV  1  clk cycles per FSM step; 1 = every cycle, 10_000_000 = 10 Hz on the 100 MHz board
// PORTS
//  clk        in   1      clock
//  reset      in   1      asynchronous, active-high
//  start      in   1      level; sampled on a tick while IDLE
//  mode       in   1      0 = SUM (term i), 1 = SQSUM (term i*i); latched at start
//  limit      in   WIDTH  inclusive upper bound on i; latched at start
//  step       in   WIDTH  index increment; latched at start; 0 is treated as 1
//  busy       out  1      state != IDLE
//  out_valid  out  1      one-clk pulse; out_buf holds a new running total
//  out_buf    out  WIDTH  last emitted total; holds between emits and after done
//  done       out  1      one-clk pulse when the run completes
//  overflow   out  1      sticky; true total exceeded 2^WIDTH-1; cleared at start/reset
// BEHAVIOUR
//  Reset value of every output is 0: busy, out_valid, out_buf, done, overflow. state = IDLE.
//  Reset mid-run aborts immediately; no pulse is emitted. The tick counter restarts at 0.
//  tick = (div_cnt == TICK_DIV-1). div_cnt wraps to 0. TICK_DIV = 1 gives tick constantly 1.
//  All FSM and datapath registers update only on clk edges where tick = 1.
//  out_valid and done are set on the tick edge and cleared on the next clk edge (1 clk wide).
//  Registers: i (WIDTH+1 bits, so i+step can never wrap), acc (WIDTH), latched mode/limit/step.
//  State machine:
//   IDLE: if start -> INIT; latch inputs; clear overflow. start while busy is ignored.
//   INIT: i <= 0, acc <= 0 -> CMP.
//   CMP:  if i <= limit -> EMIT, else -> FIN.
//   EMIT: out_buf <= acc, out_valid pulse -> INC.
//   INC:  i <= i+step; acc <= acc + term(i+step) -> CMP.
//   FIN:  done pulse; out_buf unchanged -> IDLE.
//  Arithmetic:
//   term = i (SUM) or i*i (SQSUM); the product is 2*(WIDTH+1) bits wide.
//   overflow sets if any product bits above WIDTH are nonzero.
//   overflow also sets on carry out of the WIDTH-bit add.
//   Without saturation the accumulator wraps modulo 2^WIDTH.
//   The term is computed in INC even when i+step > limit. That value is never emitted.
//  Timing at TICK_DIV = 1:
//   start sampled at edge 0 -> first out_valid after edge 3.
//   Successive out_valid pulses are 3 ticks apart.
//   done comes 3 ticks after the last out_valid.
//  Boundaries:
//   limit = 0 emits exactly one total, 0.
//   limit = 2^WIDTH-1 with step 1 terminates after 2^WIDTH emits.
//   start held high re-runs back-to-back, one IDLE tick between runs.
// CONFIGURATION
//  SEQ_ACCUM_SAT_EN defined:
//   On overflow, acc clamps to 2^WIDTH-1 and stays there for the rest of the run.
//   overflow still sets.
//  SEQ_ACCUM_SAT_EN undefined: acc wraps modulo 2^WIDTH.
// STRUCTURE
//  Package seq_accum_pkg: state_e {IDLE, INIT, CMP, EMIT, INC, FIN}; mode_e {MODE_SUM, MODE_SQSUM}.
//  Sub-module tick_gen (param TICK_DIV; clk, reset -> tick). All other logic stays in this module.
// TESTING
//  1. WIDTH=8, SUM, limit=10, step=1 ->
//     11 out_valid pulses with out_buf 0,1,3,6,10,15,21,28,36,45,55.
//     Then one done pulse. out_buf stays 55; overflow = 0.
//  2. SQSUM, limit=4, step=1 -> emits 0,1,5,14,30, then done.
//  3. SUM, limit=10, step=3 -> emits 0,3,9,18. step=0 -> same sequence as step=1.
//  4. WIDTH=8, SUM, limit=30:
//     the run reaches 276 at i=23 and overflow rises.
//     Without the macro the final total is 465 mod 256 = 209. With SEQ_ACCUM_SAT_EN it is 255.
//  5. start pulsed mid-run -> no effect on the run.
//     reset asserted mid-run -> all outputs 0 next cycle.
//     A new start then reproduces test 1 exactly.
//  6. TICK_DIV=4, test 1 stimulus -> out_valid pulses 12 clk apart, each exactly 1 clk wide.

Source files
------------

// File: rtl/seq_accum_pkg.sv
// Shared types for the sequence accumulator: FSM state encoding and term mode.
`timescale 1ns/1ps
package seq_accum_pkg;
  typedef enum logic [2:0] {IDLE, INIT, CMP, EMIT, INC, FIN} state_e;
  typedef enum logic {MODE_SUM, MODE_SQSUM} mode_e;
endpackage

// File: rtl/seq_accum_processor_tick_gen.sv
// Clock-enable generator: tick is high one clk in every TICK_DIV (constantly high for 1).
`timescale 1ns/1ps
module tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] div_cnt_q;

  assign tick = (div_cnt_q == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     div_cnt_q <= '0;
    else if (tick) div_cnt_q <= '0;
    else           div_cnt_q <= div_cnt_q + CW'(1);
  end
endmodule

// File: rtl/seq_accum_processor.sv
// Accumulates i or i*i over i = 0, step, 2*step, ... <= limit, emitting each running total.
// Define SEQ_ACCUM_SAT_EN to clamp the accumulator at 2^WIDTH-1 once it overflows.
`timescale 1ns/1ps
module seq_accum_processor
  import seq_accum_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] step,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_buf,
  output logic             done,
  output logic             overflow,
  output state_e           dbg_state_o
);
  localparam int PW = 2 * WIDTH + 2;

  logic tick;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [WIDTH:0]   i_q, i_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] step_q, step_d;
  logic [WIDTH-1:0] out_buf_q, out_buf_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   next_i;
  logic [PW-1:0]    term;
  logic [WIDTH:0]   sum;
  logic             ovf_now;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  // i is one bit wider than the datapath so i + step cannot wrap before the limit test.
  assign next_i  = i_q + {1'b0, step_q};
  assign term    = (mode_q == MODE_SQSUM) ? PW'(next_i) * PW'(next_i) : PW'(next_i);
  assign sum     = {1'b0, acc_q} + {1'b0, term[WIDTH-1:0]};
  assign ovf_now = (|term[PW-1:WIDTH]) | sum[WIDTH];

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    i_d         = i_q;
    acc_d       = acc_q;
    limit_d     = limit_q;
    step_d      = step_q;
    out_buf_d   = out_buf_q;
    overflow_d  = overflow_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = INIT;
          mode_d     = mode_e'(mode);
          limit_d    = limit;
          step_d     = (step == '0) ? WIDTH'(1) : step;
          overflow_d = 1'b0;
        end
      end
      INIT: begin
        i_d     = '0;
        acc_d   = '0;
        state_d = CMP;
      end
      CMP:  state_d = (i_q <= {1'b0, limit_q}) ? EMIT : FIN;
      EMIT: begin
        out_buf_d   = acc_q;
        out_valid_d = tick;
        state_d     = INC;
      end
      INC: begin
        i_d        = next_i;
        overflow_d = overflow_q | ovf_now;
`ifdef SEQ_ACCUM_SAT_EN
        acc_d      = (overflow_q | ovf_now) ? '1 : sum[WIDTH-1:0];
`else
        acc_d      = sum[WIDTH-1:0];
`endif
        state_d    = CMP;
      end
      FIN: begin
        done_d  = tick;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Pulses clear on the next clk edge; everything else only moves on a tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mode_q      <= MODE_SUM;
      i_q         <= '0;
      acc_q       <= '0;
      limit_q     <= '0;
      step_q      <= '0;
      out_buf_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      if (tick) begin
        state_q    <= state_d;
        mode_q     <= mode_d;
        i_q        <= i_d;
        acc_q      <= acc_d;
        limit_q    <= limit_d;
        step_q     <= step_d;
        out_buf_q  <= out_buf_d;
        overflow_q <= overflow_d;
      end
    end
  end

  assign busy        = (state_q != IDLE);
  assign out_valid   = out_valid_q;
  assign out_buf     = out_buf_q;
  assign done        = done_q;
  assign overflow    = overflow_q;
  assign dbg_state_o = state_q;
endmodule

// File: tb/tb_seq_accum_processor.sv
// Bench for seq_accum_processor: directed and random runs against a series-sum reference model.
`timescale 1ns/1ps
module tb_seq_accum_processor;
  import seq_accum_pkg::*;

  localparam int W = 8;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start, mode, start4;
  logic [W-1:0] limit, step;
  logic         busy, out_valid, done, overflow;
  logic [W-1:0] out_buf;
  state_e       dbg_state;
  logic         busy4, out_valid4, done4, overflow4;
  logic [W-1:0] out_buf4;
  state_e       dbg_state4;

  seq_accum_processor #(.WIDTH(W), .TICK_DIV(1)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .limit(limit), .step(step),
    .busy(busy), .out_valid(out_valid), .out_buf(out_buf), .done(done),
    .overflow(overflow), .dbg_state_o(dbg_state)
  );

  seq_accum_processor #(.WIDTH(W), .TICK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .mode(mode), .limit(limit), .step(step),
    .busy(busy4), .out_valid(out_valid4), .out_buf(out_buf4), .done(done4),
    .overflow(overflow4), .dbg_state_o(dbg_state4)
  );

  // scoreboard
  int           n_checks = 0;
  int           n_errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_last;
  logic         exp_ovf;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: the true (unbounded) running total of the series; emitted values are that
  // total wrapped or clamped, and overflow is whether the total, including the one extra
  // term added past the limit, ever exceeds 2^W-1.
  task automatic model(input logic m, input logic [W-1:0] lim, input logic [W-1:0] st);
    longint total = 0;
    longint s = (st == 0) ? 1 : longint'(st);
    longint nxt;
    exp_q.delete();
    for (longint i = 0; i <= longint'(lim); i += s) begin
`ifdef SEQ_ACCUM_SAT_EN
      exp_q.push_back((total > 255) ? W'(255) : W'(total));
`else
      exp_q.push_back(W'(total % 256));
`endif
      nxt = i + s;
      total += m ? nxt * nxt : nxt;
    end
    exp_last = exp_q[exp_q.size()-1];
    exp_ovf  = (total > 255);
  endtask

  // driver: one run on the TICK_DIV=1 instance, checking values and pulse timing
  task automatic do_run(input logic m, input logic [W-1:0] lim, input logic [W-1:0] st,
                        input bit mid_start, input string tag);
    int cyc, last, n_emit, n_exp;
    bit got_done;
    model(m, lim, st);
    n_exp = exp_q.size();
    @(negedge clk);
    mode = m; limit = lim; step = st; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1; last = -1; n_emit = 0; got_done = 1'b0;
    check_eq({tag, "_busy"}, busy, 1);
    while (!got_done && cyc < 5000) begin
      if (cyc == 2) begin
        mode = 1'($urandom_range(0, 1)); limit = W'($urandom_range(0, 255));
        step = W'($urandom_range(0, 255));
      end
      if (mid_start && cyc == 5) start = 1'b1;
      if (mid_start && cyc == 6) start = 1'b0;
      if (out_valid) begin
        if (exp_q.size() != 0) check_eq({tag, "_val"}, out_buf, exp_q.pop_front());
        else check_eq({tag, "_extra_emit"}, n_emit + 1, n_exp);
        if (last < 0) check_eq({tag, "_first_lat"}, cyc, 4);
        else check_eq({tag, "_gap"}, cyc - last, 3);
        last = cyc;
        n_emit++;
      end
      if (done) begin
        got_done = 1'b1;
        check_eq({tag, "_done_gap"}, cyc - last, 3);
        check_eq({tag, "_final"}, out_buf, exp_last);
        check_eq({tag, "_ovf"}, overflow, exp_ovf);
        check_eq({tag, "_busy_end"}, busy, 0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check_eq({tag, "_done_seen"}, got_done, 1);
    check_eq({tag, "_n_emit"}, n_emit, n_exp);
    @(negedge clk);
    check_eq({tag, "_done_width"}, done, 0);
  endtask

  initial begin
    int cyc, last, n;
    bit pend;
    reset = 1'b1; start = 1'b0; start4 = 1'b0; mode = 1'b0; limit = '0; step = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_buf", out_buf, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_overflow", overflow, 0);
    check_eq("rst_state", dbg_state, IDLE);
    reset = 1'b0;

    do_run(1'b0, 8'd10, 8'd1, 1'b0, "t1_sum");
    do_run(1'b1, 8'd4, 8'd1, 1'b0, "t2_sqsum");
    do_run(1'b0, 8'd10, 8'd3, 1'b0, "t3_step3");
    do_run(1'b0, 8'd10, 8'd0, 1'b0, "t3_step0");
    do_run(1'b0, 8'd30, 8'd1, 1'b0, "t4_ovf");
    do_run(1'b0, 8'd0, 8'd1, 1'b0, "lim0");
    do_run(1'b0, 8'd255, 8'd1, 1'b0, "lim_max");
    do_run(1'b0, 8'd10, 8'd1, 1'b1, "t5_midstart");

    // reset mid-run
    @(negedge clk);
    mode = 1'b0; limit = 8'd10; step = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    check_eq("t5_rst_busy", busy, 0);
    check_eq("t5_rst_out_valid", out_valid, 0);
    check_eq("t5_rst_out_buf", out_buf, 0);
    check_eq("t5_rst_done", done, 0);
    check_eq("t5_rst_overflow", overflow, 0);
    @(negedge clk);
    reset = 1'b0;
    do_run(1'b0, 8'd10, 8'd1, 1'b0, "t5_rerun");

    // start held high: back-to-back runs with one IDLE tick between
    @(negedge clk);
    mode = 1'b0; limit = 8'd0; step = 8'd1; start = 1'b1;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("b2b_done_seen", done, 1);
    check_eq("b2b_idle_gap", busy, 0);
    @(negedge clk);
    check_eq("b2b_restart", busy, 1);
    cyc = 1;
    while (!out_valid && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("b2b_emit_lat", cyc, 4);
    check_eq("b2b_val", out_buf, 0);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 100) begin @(negedge clk); cyc++; end
    check_eq("b2b_done2", done, 1);
    repeat (3) @(negedge clk);
    check_eq("b2b_no_third", busy, 0);

    // random runs
    for (int r = 0; r < 20; r++) begin
      logic [W-1:0] rl, rs;
      logic rm;
      rm = 1'($urandom_range(0, 1));
      rl = W'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 8));
      do_run(rm, rl, rs, 1'b0, "rnd");
    end

    // TICK_DIV = 4 instance with the first directed stimulus
    mode = 1'b0; limit = 8'd10; step = 8'd1;
    model(1'b0, 8'd10, 8'd1);
    @(negedge clk);
    start4 = 1'b1;
    cyc = 0;
    while (!busy4 && cyc < 20) begin @(negedge clk); cyc++; end
    check_eq("t6_start", busy4, 1);
    start4 = 1'b0;
    last = -1; n = 0; cyc = 0; pend = 1'b0;
    while (!done4 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (pend) begin
        check_eq("t6_width", out_valid4, 0);
        pend = 1'b0;
      end else if (out_valid4) begin
        if (exp_q.size() != 0) check_eq("t6_val", out_buf4, exp_q.pop_front());
        if (last >= 0) check_eq("t6_gap", cyc - last, 12);
        last = cyc;
        n++;
        pend = 1'b1;
      end
    end
    check_eq("t6_done_seen", done4, 1);
    check_eq("t6_n_emit", n, 11);
    check_eq("t6_final", out_buf4, 55);
    @(negedge clk);
    check_eq("t6_done_width", done4, 0);

    // report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
